astropix_layer_emu: RTL and testbench
=====================================

ASTROPIX_LAYER_EMU -- requirements
Module: astropix_layer_emu

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8 (power of 2, >=2), hit-word FIFO entries.
REQ-002 SHALL have parameter CHIP_ID, default 3'd0, placed in frame header bits [7:5].
REQ-003 SHALL have parameter IDLE_BYTE, default 8'hBC, byte sent when no frame is pending.
REQ-004 sysclk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 spi_clk  in  1  layer SPI clock from readout master, async to sysclk, mode 0.
REQ-007 spi_csn  in  1  layer chip select, active low, async.
REQ-008 spi_mosi  in  1  master-to-layer serial data, async.
REQ-009 spi_miso  out  2  layer-to-master data, 2 lanes.
REQ-010 interruptn  out  1  low while hit data pending.
REQ-011 hit_valid  in  1  hit word offered.
REQ-012 hit_data  in  32  hit payload.
REQ-013 hit_ready  out  1  FIFO can accept (= not full).
REQ-014 mosi_byte_valid  out  1  one-cycle pulse: MOSI byte complete.
REQ-015 mosi_byte  out  8  last complete MOSI byte.
REQ-016 drop_count  out  8  saturating count of hits offered while full.
REQ-017 frame_abort  out  1  one-cycle pulse: csn rose mid-frame.

Function
REQ-018 spi_clk, spi_csn, spi_mosi SHALL pass 2-flop synchronizers; edges detected on synchronized copies; sysclk >= 8x spi_clk required.
REQ-019 Push when hit_valid && hit_ready; pop only at header load; simultaneous push/pop SHALL leave count unchanged.
REQ-020 hit_valid && !hit_ready SHALL drop the word and increment drop_count, saturating at 255.
REQ-021 interruptn SHALL be registered, low the cycle after FIFO count becomes nonzero, high the cycle after it becomes zero.
REQ-022 Frame = header {CHIP_ID, 5'd4} then hit_data[31:24], [23:16], [15:8], [7:0].
REQ-023 States: IDLE (idle byte loaded), HDR, PAY0..PAY3; byte selection at each byte boundary: IDLE/PAY3 -> HDR if FIFO nonempty (pop, latch word) else IDLE; HDR -> PAY0; PAYn -> PAYn+1.
REQ-024 Synchronized csn fall SHALL make a byte-boundary selection and drive bits [7:6] of the chosen byte within 1 sysclk.
REQ-025 Each byte: miso[1] = bit 7-2k, miso[0] = bit 6-2k, k=0..3; updated on synchronized spi_clk falling edge; 4 falling edges complete a byte, the 4th loading the next byte.
REQ-026 While csn high SHALL drive spi_miso = 2'b00 and hold bit counters at 0.
REQ-027 csn rise in HDR/PAYn SHALL pulse frame_abort, discard the latched word, return to IDLE; rise in IDLE SHALL not pulse.
REQ-028 MOSI sampled MSB first on synchronized spi_clk rising edges while csn low; 8th bit SHALL update mosi_byte and pulse mosi_byte_valid 1 cycle later; csn rise clears partial byte.
REQ-029 spi_clk edges while csn high SHALL be ignored.

Reset
REQ-030 rst SHALL empty FIFO, state IDLE, spi_miso=0, interruptn=1, hit_ready=1, drop_count=0, mosi_byte=0, mosi_byte_valid=0, frame_abort=0.
REQ-031 rst asserted mid-transfer SHALL override; transfer resumes only after next csn fall.

Verification
REQ-032 Push 32'hDEADBEEF, CHIP_ID=5; csn low, 20 clocks -> interruptn low then high after pop; miso bytes A4 DE AD BE EF.
REQ-033 Empty FIFO, csn low, 8 clocks -> bytes BC BC, interruptn stays 1, frame_abort never pulses.
REQ-034 Push 10 words, FIFO_DEPTH=8 -> hit_ready low after 8, drop_count=2; read 40 bytes -> first 8 words in order, then BC.
REQ-035 Push 1 word, csn low, 8 clocks, csn high -> frame_abort pulses once; next transaction starts with BC (word lost).
REQ-036 MOSI 8'hA5 then 8'h3C with csn low -> two mosi_byte_valid pulses, mosi_byte A5 then 3C.
REQ-037 rst during PAY1 with 2 words queued -> outputs at reset values, drop_count=0, next read yields BC.

Source files
------------

// File: rtl/astropix_layer_emu.sv
`default_nettype none
// ============================================================================
// Module   : astropix_layer_emu
// Brief    : AstroPix layer emulator. Queues 32-bit hit words and serves
//            5-byte frames over a 2-lane SPI slave clocked by sysclk.
// Revision : 1.0 - initial release
// ============================================================================
module astropix_layer_emu #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [2:0] CHIP_ID    = 3'd0,
    parameter logic [7:0] IDLE_BYTE  = 8'hBC
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic [1:0]  spi_miso,
    output logic        interruptn,
    input  logic        hit_valid,
    input  logic [31:0] hit_data,
    output logic        hit_ready,
    output logic        mosi_byte_valid,
    output logic [7:0]  mosi_byte,
    output logic [7:0]  drop_count,
    output logic        frame_abort
);

    localparam int            c_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]    c_HDR  = {CHIP_ID, 5'd4};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_PAY0 = 3'd2;
    localparam logic [2:0] S_PAY1 = 3'd3;
    localparam logic [2:0] S_PAY2 = 3'd4;
    localparam logic [2:0] S_PAY3 = 3'd5;

    // csn synchronizer resets low so a csn held low through reset never
    // looks like a fresh fall; a new transfer needs a real high-then-low.
    logic [2:0] r_sclk_sync;
    logic [2:0] r_csn_sync;
    logic [1:0] r_mosi_sync;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_sclk_sync <= 3'b000;
            r_csn_sync  <= 3'b000;
            r_mosi_sync <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi_clk};
            r_csn_sync  <= {r_csn_sync[1:0], spi_csn};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
        end
    end

    logic r_active;
    logic w_csn_fall, w_csn_rise, w_sclk_rise_act, w_sclk_fall_act;

    assign w_csn_fall      =  r_csn_sync[2] & ~r_csn_sync[1];
    assign w_csn_rise      = ~r_csn_sync[2] &  r_csn_sync[1];
    assign w_sclk_rise_act = r_active & ~w_csn_rise &  r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall_act = r_active & ~w_csn_rise & ~r_sclk_sync[1] &  r_sclk_sync[2];

    // ---------------- hit FIFO ----------------
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_empty, w_full, w_push, w_pop;
    logic [7:0]      r_drop;
    logic            r_intn;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);
    assign w_push    = hit_valid & ~w_full;
    assign hit_ready = ~w_full;

    always_ff @(posedge sysclk) begin
        if (w_push) r_mem[r_wr_ptr] <= hit_data;
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 8'd0;
            r_intn   <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (hit_valid && w_full && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
            r_intn <= w_empty;
        end
    end

    assign drop_count = r_drop;
    assign interruptn = r_intn;

    // ---------------- frame transmitter ----------------
    logic [2:0]  r_state, w_state_nxt;
    logic [7:0]  r_shift, w_byte_nxt;
    logic [1:0]  r_txcnt;
    logic [31:0] r_word;
    logic        r_abort, w_abort, w_load;

    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = IDLE_BYTE;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_abort     = 1'b0;
        if (w_csn_rise && r_active) begin
            w_state_nxt = S_IDLE;
            w_abort     = (r_state != S_IDLE);
        end else if (w_csn_fall || (w_sclk_fall_act && (r_txcnt == 2'd3))) begin
            w_load = 1'b1;
            case (r_state)
                S_HDR:  begin w_state_nxt = S_PAY0; w_byte_nxt = r_word[31:24]; end
                S_PAY0: begin w_state_nxt = S_PAY1; w_byte_nxt = r_word[23:16]; end
                S_PAY1: begin w_state_nxt = S_PAY2; w_byte_nxt = r_word[15:8];  end
                S_PAY2: begin w_state_nxt = S_PAY3; w_byte_nxt = r_word[7:0];   end
                default: begin
                    if (!w_empty) begin
                        w_state_nxt = S_HDR;
                        w_byte_nxt  = c_HDR;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
            r_shift  <= 8'd0;
            r_txcnt  <= 2'd0;
            r_word   <= 32'd0;
            r_abort  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_abort <= w_abort;
            if (w_pop) r_word <= r_mem[r_rd_ptr];
            if (w_csn_fall)      r_active <= 1'b1;
            else if (w_csn_rise) r_active <= 1'b0;
            if (w_load)               r_shift <= w_byte_nxt;
            else if (w_sclk_fall_act) r_shift <= {r_shift[5:0], 2'b00};
            if (!r_active || w_csn_rise || w_csn_fall) r_txcnt <= 2'd0;
            else if (w_sclk_fall_act)                   r_txcnt <= r_txcnt + 2'd1;
        end
    end

    assign spi_miso    = r_active ? r_shift[7:6] : 2'b00;
    assign frame_abort = r_abort;

    // ---------------- MOSI receiver ----------------
    logic [6:0] r_mosi_sh;
    logic [2:0] r_mosi_cnt;
    logic [7:0] r_mosi_byte;
    logic       r_mosi_valid;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_mosi_sh    <= 7'd0;
            r_mosi_cnt   <= 3'd0;
            r_mosi_byte  <= 8'd0;
            r_mosi_valid <= 1'b0;
        end else begin
            r_mosi_valid <= 1'b0;
            if (!r_active || w_csn_rise) begin
                r_mosi_cnt <= 3'd0;
            end else if (w_sclk_rise_act) begin
                r_mosi_sh  <= {r_mosi_sh[5:0], r_mosi_sync[1]};
                r_mosi_cnt <= r_mosi_cnt + 3'd1;
                if (r_mosi_cnt == 3'd7) begin
                    r_mosi_byte  <= {r_mosi_sh, r_mosi_sync[1]};
                    r_mosi_valid <= 1'b1;
                end
            end
        end
    end

    assign mosi_byte       = r_mosi_byte;
    assign mosi_byte_valid = r_mosi_valid;

endmodule
`default_nettype wire

// File: tb/tb_astropix_layer_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_astropix_layer_emu
// Brief    : Self-checking bench: SPI master, hit driver and a queue-based
//            frame model for astropix_layer_emu.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_astropix_layer_emu;

    localparam int         DEPTH = 8;
    localparam logic [7:0] HDR   = 8'hA4;
    localparam logic [7:0] IDLEB = 8'hBC;
    localparam int         HALF  = 60;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
    logic [1:0]  spi_miso;
    logic        interruptn;
    logic        hit_valid = 1'b0;
    logic [31:0] hit_data = 32'd0;
    logic        hit_ready;
    logic        mosi_byte_valid;
    logic [7:0]  mosi_byte;
    logic [7:0]  drop_count;
    logic        frame_abort;

    astropix_layer_emu #(.FIFO_DEPTH(DEPTH), .CHIP_ID(3'd5), .IDLE_BYTE(8'hBC)) dut (
        .sysclk(sysclk), .rst(rst), .spi_clk(spi_clk), .spi_csn(spi_csn),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .interruptn(interruptn),
        .hit_valid(hit_valid), .hit_data(hit_data), .hit_ready(hit_ready),
        .mosi_byte_valid(mosi_byte_valid), .mosi_byte(mosi_byte),
        .drop_count(drop_count), .frame_abort(frame_abort)
    );

    always #5 sysclk = ~sysclk;

    logic [31:0] mq[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  exp_mosi_q[$];
    logic [7:0]  mosi_log[$];
    logic [7:0]  rx_log[$];
    int          m_drop = 0;
    bit          cur_frame = 1'b0;
    logic [7:0]  cur_exp = 8'd0;
    logic [7:0]  rx = 8'd0;
    int          rx_n = 0;
    logic [7:0]  m_sh = 8'd0;
    int          m_n = 0;
    int          abort_seen = 0, abort_exp = 0;
    bit          chk_fifo = 1'b0, chk_int = 1'b1;
    int          n_vec = 0, n_err = 0;

    function automatic void check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Next byte the layer must present: rest of current frame, else a new
    // frame built from the oldest queued word, else the idle byte.
    function automatic void sel_next();
        logic [31:0] w;
        if (frame_q.size() > 0) begin
            cur_exp   = frame_q.pop_front();
            cur_frame = 1'b1;
        end else if (mq.size() > 0) begin
            w = mq.pop_front();
            frame_q.push_back(w[31:24]);
            frame_q.push_back(w[23:16]);
            frame_q.push_back(w[15:8]);
            frame_q.push_back(w[7:0]);
            cur_exp   = HDR;
            cur_frame = 1'b1;
        end else begin
            cur_exp   = IDLEB;
            cur_frame = 1'b0;
        end
    endfunction

    task automatic push_word(input logic [31:0] d);
        chk_int = 1'b0;
        @(posedge sysclk); #1;
        hit_valid = 1'b1;
        hit_data  = d;
        @(posedge sysclk);
        if (mq.size() < DEPTH) mq.push_back(d);
        else if (m_drop < 255) m_drop++;
        #1 hit_valid = 1'b0;
        @(posedge sysclk); #1;
        chk_int = 1'b1;
    endtask

    task automatic csn_low();
        chk_fifo = 1'b0;
        #3 spi_csn = 1'b0;
        sel_next();
        rx_n = 0;
        m_n  = 0;
        #(HALF);
    endtask

    task automatic spi_clock(input bit m);
        spi_mosi = m;
        #(HALF);
        rx = {rx[5:0], spi_miso};
        spi_clk = 1'b1;
        m_sh = {m_sh[6:0], m};
        m_n++;
        if (m_n == 8) begin
            exp_mosi_q.push_back(m_sh);
            m_n = 0;
        end
        #(HALF);
        spi_clk = 1'b0;
        rx_n++;
        if (rx_n == 4) begin
            check("miso_byte", int'(rx), int'(cur_exp));
            rx_log.push_back(rx);
            sel_next();
            rx_n = 0;
        end
    endtask

    task automatic csn_high();
        #(HALF);
        spi_csn = 1'b1;
        if (cur_frame) begin
            abort_exp++;
            frame_q.delete();
        end
        cur_frame = 1'b0;
        m_n  = 0;
        rx_n = 0;
        repeat (8) @(posedge sysclk);
        #1;
        check("frame_abort_cnt", abort_seen, abort_exp);
        check("mosi_missing", exp_mosi_q.size(), 0);
        chk_fifo = 1'b1;
    endtask

    task automatic xfer(input int nbytes, input logic [31:0] mbits, input bit use_m);
        bit m;
        csn_low();
        for (int i = 0; i < nbytes * 4; i++) begin
            if (use_m) m = (i < 32) ? mbits[31 - i] : 1'b0;
            else       m = 1'($urandom_range(0, 1));
            spi_clock(m);
        end
        csn_high();
    endtask

    // Per-cycle compare against the model.
    always @(negedge sysclk) begin
        if (!rst) begin
            if (mosi_byte_valid) begin
                mosi_log.push_back(mosi_byte);
                if (exp_mosi_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL mosi_extra: got byte %0h expected no pulse", mosi_byte);
                end else begin
                    check("mosi_byte", int'(mosi_byte), int'(exp_mosi_q.pop_front()));
                end
            end
            if (frame_abort) abort_seen++;
            if (chk_fifo) begin
                check("hit_ready", int'(hit_ready), int'(mq.size() < DEPTH));
                check("drop_count", int'(drop_count), m_drop);
                check("miso_idle", int'(spi_miso), 0);
                if (chk_int) check("interruptn", int'(interruptn), int'(mq.size() == 0));
            end
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ab0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_miso", int'(spi_miso), 0);
        check("rst_intn", int'(interruptn), 1);
        check("rst_ready", int'(hit_ready), 1);
        check("rst_drop", int'(drop_count), 0);
        check("rst_mbyte", int'(mosi_byte), 0);
        rst = 1'b0;
        repeat (4) @(posedge sysclk);
        #1 chk_fifo = 1'b1;

        // one frame, DEADBEEF
        push_word(32'hDEADBEEF);
        check("int_low", int'(interruptn), 0);
        rx_log.delete();
        xfer(5, 32'd0, 1'b1);
        check("b0", int'(rx_log[0]), 8'hA4);
        check("b1", int'(rx_log[1]), 8'hDE);
        check("b2", int'(rx_log[2]), 8'hAD);
        check("b3", int'(rx_log[3]), 8'hBE);
        check("b4", int'(rx_log[4]), 8'hEF);
        check("int_high", int'(interruptn), 1);

        // empty FIFO gives idle bytes, no abort
        ab0 = abort_seen;
        rx_log.delete();
        xfer(2, 32'd0, 1'b1);
        check("idle0", int'(rx_log[0]), 8'hBC);
        check("idle1", int'(rx_log[1]), 8'hBC);
        check("no_abort", abort_seen, ab0);

        // MOSI A5 then 3C
        mosi_log.delete();
        xfer(4, 32'hA53C_0000, 1'b1);
        check("mosi_n", mosi_log.size(), 2);
        check("mosi0", int'(mosi_log[0]), 8'hA5);
        check("mosi1", int'(mosi_log[1]), 8'h3C);

        // overflow: 10 pushes into depth 8
        for (int i = 0; i < 10; i++) push_word({8'(i), 8'hA0, 8'hB0, 8'hC0});
        check("ovf_drop", int'(drop_count), 2);
        check("ovf_ready", int'(hit_ready), 0);
        rx_log.delete();
        xfer(42, 32'd0, 1'b1);
        check("ovf_w7", int'(rx_log[36]), 8'd7);
        check("ovf_idle", int'(rx_log[40]), 8'hBC);

        // abort mid-frame loses the word
        push_word(32'h11223344);
        ab0 = abort_seen;
        xfer(2, 32'd0, 1'b1);
        check("abort_once", abort_seen, ab0 + 1);
        rx_log.delete();
        xfer(1, 32'd0, 1'b1);
        check("after_abort", int'(rx_log[0]), 8'hBC);

        // reset during PAY1 with two words queued
        push_word(32'h55667788);
        push_word(32'h99AABBCC);
        csn_low();
        for (int i = 0; i < 9; i++) spi_clock(1'b0);
        chk_fifo = 1'b0;
        @(posedge sysclk); #1 rst = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        check("mid_rst_miso", int'(spi_miso), 0);
        check("mid_rst_intn", int'(interruptn), 1);
        check("mid_rst_ready", int'(hit_ready), 1);
        check("mid_rst_drop", int'(drop_count), 0);
        check("mid_rst_mbyte", int'(mosi_byte), 0);
        check("mid_rst_abort", int'(frame_abort), 0);
        mq.delete();
        frame_q.delete();
        exp_mosi_q.delete();
        m_drop = 0;
        cur_frame = 1'b0;
        rst = 1'b0;
        csn_high();
        rx_log.delete();
        xfer(1, 32'd0, 1'b1);
        check("post_rst", int'(rx_log[0]), 8'hBC);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            int np;
            np = $urandom_range(0, 4);
            for (int p = 0; p < np; p++) push_word($urandom);
            xfer($urandom_range(1, 12), 32'd0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
